// File: rtl/gdiv_pkg.sv
// Shared state encoding, default parameters and saturation limits for the Goldschmidt divider.
package gdiv_pkg;

    localparam int GDIV_WIDTH    = 16;
    localparam int GDIV_FRAC     = 8;
    localparam int GDIV_ITERS    = 4;
    localparam int GDIV_LUT_BITS = 4;
    localparam int GDIV_GUARD    = 6;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        SEED,
        ITER,
        FIX,
        DONE
    } gdiv_state_e;

    // Largest quotient magnitude representable for the given sign.
    function automatic logic [63:0] sat_limit(input int width, input logic neg);
        logic [63:0] half;
        half = 64'd1 << (width - 1);
        return neg ? half : (half - 64'd1);
    endfunction

endpackage

// File: rtl/gdiv_seed_lut.sv
// Reciprocal seed table: entry i holds 1/midpoint of the divisor interval [0.5+i/2^(L+1), 0.5+(i+1)/2^(L+1)).
module gdiv_seed_lut
    import gdiv_pkg::*;
#(
    parameter int LUT_BITS = GDIV_LUT_BITS,
    parameter int IF_BITS  = GDIV_WIDTH + GDIV_GUARD
) (
    input  logic [LUT_BITS-1:0] idx,
    output logic [IF_BITS:0]    seed
);

    logic [IF_BITS:0] table_w [2**LUT_BITS];

    for (genvar i = 0; i < 2**LUT_BITS; i++) begin : g_entry
        localparam logic [63:0] DEN = (64'd1 << (LUT_BITS + 1)) + 64'(2 * i + 1);
        localparam logic [63:0] VAL = (64'd1 << (IF_BITS + LUT_BITS + 2)) / DEN;
        assign table_w[i] = VAL[IF_BITS:0];
    end

    assign seed = table_w[idx];

endmodule

// File: rtl/gs_divider_iter.sv
// Iterative Goldschmidt divider for signed Q(WIDTH-FRAC-1).FRAC operands with valid/ready handshakes.
// Define GDIV_ROUND_EN to round half away from zero; otherwise the quotient truncates toward zero.
//
// state | meaning
// IDLE  | in_ready high, capture sign and operand magnitudes
// NORM  | leading-one detect, scale |N| and |D| so Dn is in [0.5,1)
// SEED  | multiply both by the table reciprocal F0
// ITER  | N*=F, D*=F with F=2-D, ITERS passes
// FIX   | round/truncate, saturate, apply sign, form divide-by-zero result
// DONE  | out_valid high, hold until out_ready
module gs_divider_iter
    import gdiv_pkg::*;
#(
    parameter int WIDTH    = GDIV_WIDTH,
    parameter int FRAC     = GDIV_FRAC,
    parameter int ITERS    = GDIV_ITERS,
    parameter int LUT_BITS = GDIV_LUT_BITS,
    parameter int GUARD    = GDIV_GUARD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] No,
    output logic             dz,
    output logic             ovf
);

    localparam int IF_BITS = WIDTH + GUARD;
    localparam int DW      = IF_BITS + 1;
    localparam int NI      = WIDTH - FRAC + 2;
    localparam int NW      = NI + IF_BITS;
    localparam int XW      = WIDTH + IF_BITS - 1;
    localparam int SW      = $clog2(IF_BITS);
    localparam int RSH     = IF_BITS - FRAC;
    localparam int QW      = NW - RSH;
    localparam int CW      = 4;

    localparam logic [NW-1:0]    BIAS    = NW'(1) << (RSH - 4);
    localparam logic [NW-1:0]    HALF    = NW'(1) << (RSH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    gdiv_state_e state, nxt;

    logic             p_q;
    logic             n_sign_q;
    logic             big_q;
    logic [WIDTH-1:0] mag_n_q;
    logic [WIDTH-1:0] mag_d_q;
    logic [NW-1:0]    n_q;
    logic [DW-1:0]    d_q;
    logic [CW-1:0]    cnt_q;

    logic [SW-1:0]      sh;
    logic [XW-1:0]      wide_n;
    logic [XW-1:0]      wide_d;
    logic               n_big;
    logic [DW-1:0]      seed;
    logic [IF_BITS+1:0] two_m_d;
    logic [DW-1:0]      f_mul;
    logic [NW+DW-1:0]   prod_n;
    logic [2*DW-1:0]    prod_d;
    logic [NW-1:0]      n_adj;
    logic [QW-1:0]      mag_q;
    logic [63:0]        lim;
    logic               sat;
    logic [WIDTH-1:0]   res;
    logic               res_ovf;
    logic               unused_bits;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (in_valid) nxt = NORM;
            NORM:    nxt = (mag_d_q == '0) ? FIX : SEED;
            SEED:    nxt = ITER;
            ITER:    if (cnt_q == '0) nxt = FIX;
            FIX:     nxt = DONE;
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);

    // N is scaled by the same shift as D, so the converged N is already the quotient.
    always_comb begin
        sh = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag_d_q[i]) sh = SW'(IF_BITS - 1 - i);
        end
    end

    assign wide_n = XW'(mag_n_q) << sh;
    assign wide_d = XW'(mag_d_q) << sh;
    // A scaled dividend at or above 2^(WIDTH-FRAC) already guarantees saturation.
    assign n_big  = |wide_n[XW-1:IF_BITS+WIDTH-FRAC];

    gdiv_seed_lut #(
        .LUT_BITS(LUT_BITS),
        .IF_BITS (IF_BITS)
    ) u_seed (
        .idx (d_q[IF_BITS-2 -: LUT_BITS]),
        .seed(seed)
    );

    assign two_m_d = {2'b10, {IF_BITS{1'b0}}} - (IF_BITS+2)'(d_q);
    assign f_mul   = (state == SEED) ? seed : two_m_d[DW-1:0];
    assign prod_n  = (NW+DW)'(n_q) * (NW+DW)'(f_mul);
    assign prod_d  = (2*DW)'(d_q) * (2*DW)'(f_mul);

    // The small bias absorbs the downward drift of the truncated iterations.
    always_comb begin
        n_adj = n_q + BIAS;
`ifdef GDIV_ROUND_EN
        n_adj = n_adj + HALF;
`endif
        mag_q   = n_adj[NW-1:RSH];
        lim     = sat_limit(WIDTH, p_q);
        sat     = big_q || (64'(mag_q) > lim);
        res     = '0;
        res_ovf = 1'b0;
        if (mag_d_q == '0) begin
            if (mag_n_q == '0) res = '0;
            else if (n_sign_q) res = MIN_NEG;
            else               res = MAX_POS;
        end else if (sat) begin
            res     = p_q ? MIN_NEG : MAX_POS;
            res_ovf = 1'b1;
        end else begin
            res = p_q ? (~mag_q[WIDTH-1:0] + 1'b1) : mag_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q      <= 1'b0;
            n_sign_q <= 1'b0;
            big_q    <= 1'b0;
            mag_n_q  <= '0;
            mag_d_q  <= '0;
            n_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            No       <= '0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    p_q      <= N[WIDTH-1] ^ D[WIDTH-1];
                    n_sign_q <= N[WIDTH-1];
                    mag_n_q  <= N[WIDTH-1] ? (~N + 1'b1) : N;
                    mag_d_q  <= D[WIDTH-1] ? (~D + 1'b1) : D;
                end
                NORM: begin
                    n_q   <= wide_n[NW-1:0];
                    d_q   <= wide_d[DW-1:0];
                    big_q <= n_big;
                end
                SEED: begin
                    n_q   <= prod_n[IF_BITS +: NW];
                    d_q   <= prod_d[IF_BITS +: DW];
                    cnt_q <= CW'(ITERS - 1);
                end
                ITER: begin
                    n_q <= prod_n[IF_BITS +: NW];
                    d_q <= prod_d[IF_BITS +: DW];
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    No  <= res;
                    dz  <= (mag_d_q == '0);
                    ovf <= res_ovf;
                end
                default: ;
            endcase
        end
    end

    assign unused_bits = ^{prod_n[NW+DW-1], prod_n[IF_BITS-1:0], prod_d[2*DW-1],
                           prod_d[IF_BITS-1:0], wide_d[XW-1:DW], n_adj[RSH-1:0],
                           two_m_d[IF_BITS+1:DW]};

endmodule

// File: tb/tb_gs_divider_iter.sv
// Directed-vector bench for gs_divider_iter at default parameters (Q7.8).
module tb_gs_divider_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] N;
    logic [15:0] D;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] No;
    logic        dz;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gs_divider_iter dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .N        (N),
        .D        (D),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .No       (No),
        .dz       (dz),
        .ovf      (ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_vec(input string name, input logic [15:0] n, input logic [15:0] d,
                           input logic [15:0] q, input logic e_dz, input logic e_ovf,
                           input int lat);
        int cyc;
        check_eq({name, "_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        N        = n;
        D        = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        N        = 16'hA5A5;
        D        = 16'h5A5A;
        cyc      = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({name, "_lat"}, 32'(cyc), 32'(lat));
        check_eq({name, "_no"}, 32'(No), 32'(q));
        check_eq({name, "_dz"}, 32'(dz), 32'(e_dz));
        check_eq({name, "_ovf"}, 32'(ovf), 32'(e_ovf));
        check_eq({name, "_busy"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_eq({name, "_release"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen;
        logic [15:0] q_third;
        logic [15:0] q_nthird;
        logic [15:0] q_half;
`ifdef GDIV_ROUND_EN
        q_third  = 16'h00AB;
        q_nthird = 16'hFF55;
        q_half   = 16'h0001;
`else
        q_third  = 16'h00AA;
        q_nthird = 16'hFF56;
        q_half   = 16'h0000;
`endif
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        N         = '0;
        D         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_outputs", 32'({No, dz, ovf}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_vec("pos_1p5",   16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 8);
        run_vec("neg_1p5",   16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 8);
        run_vec("two_third", 16'h0200, 16'h0300, q_third,  1'b0, 1'b0, 8);
        run_vec("ntwo_third",16'hFE00, 16'h0300, q_nthird, 1'b0, 1'b0, 8);
        run_vec("half_lsb",  16'h0001, 16'h0200, q_half,   1'b0, 1'b0, 8);
        run_vec("one",       16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 8);
        run_vec("m1_half",   16'hFF00, 16'h0080, 16'hFE00, 1'b0, 1'b0, 8);
        run_vec("big_div",   16'h1000, 16'h7FFF, 16'h0020, 1'b0, 1'b0, 8);
        run_vec("max_pos",   16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 1'b0, 8);
        run_vec("min_neg",   16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 8);
        run_vec("dz_pos",    16'h0500, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 3);
        run_vec("dz_neg",    16'hFB00, 16'h0000, 16'h8000, 1'b1, 1'b0, 3);
        run_vec("dz_zero",   16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 3);
        run_vec("ovf_tiny",  16'h7F00, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 8);
        run_vec("ovf_m128",  16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1, 8);

        // Stall with out_ready low while new operands are offered to the busy block.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        N         = 16'h0300;
        D         = 16'h0200;
        @(posedge clk); #1;
        N   = 16'h0100;
        D   = 16'h0100;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("stall_lat", 32'(cyc), 32'd8);
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_no", 32'({No, dz, ovf}), 32'({16'h0180, 2'b00}));
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("stall_release", 32'({out_valid, in_ready}), 32'b01);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (!in_ready || out_valid) seen++;
        end
        check_eq("stall_no_capture", 32'(seen), 32'd0);

        // Reset during the fourth cycle of an operation.
        in_valid = 1'b1;
        N        = 16'h0300;
        D        = 16'h0200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_eq("midrst_idle", 32'({out_valid, in_ready}), 32'b01);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("midrst_no_output", 32'(seen), 32'd0);

        run_vec("after_rst", 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
